// File: rtl/mining_job_if.sv
// Job, core-fanout and result signals of the mining job sequencer.
// The master side is the sequencer; the slave side is the host plus the cores.
interface mining_job_if #(
  parameter int NUM_CORES = 4
);
  logic                     job_valid;
  logic                     job_ready;
  logic [95:0]              job_data;
  logic [255:0]             job_midstate;
  logic [255:0]             job_target;
  logic                     job_abort;

  logic [NUM_CORES-1:0]     core_en;
  logic [95:0]              core_data;
  logic [255:0]             core_midstate;
  logic [255:0]             core_target;
  logic [NUM_CORES*32-1:0]  core_nonce_base;
  logic [NUM_CORES-1:0]     core_found;
  logic [NUM_CORES*32-1:0]  core_nonce;
  logic [NUM_CORES*256-1:0] core_hash;
  logic [NUM_CORES-1:0]     core_end;

  logic                     res_valid;
  logic                     res_ready;
  logic                     res_found;
  logic [31:0]              res_nonce;
  logic [255:0]             res_hash;

  modport master (
    input  job_valid, job_data, job_midstate, job_target, job_abort,
    input  core_found, core_nonce, core_hash, core_end,
    input  res_ready,
    output job_ready,
    output core_en, core_data, core_midstate, core_target, core_nonce_base,
    output res_valid, res_found, res_nonce, res_hash
  );

  modport slave (
    output job_valid, job_data, job_midstate, job_target, job_abort,
    output core_found, core_nonce, core_hash, core_end,
    output res_ready,
    input  job_ready,
    input  core_en, core_data, core_midstate, core_target, core_nonce_base,
    input  res_valid, res_found, res_nonce, res_hash
  );
endinterface

// File: rtl/mining_job_ctrl.sv
// Job sequencer for double-SHA256 mining cores: splits the nonce space,
// runs the cores, drains their pipelines and reports one result.
module mining_job_ctrl #(
  parameter int NUM_CORES    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mining_job_if.master  bus,
  output logic          busy
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  function automatic logic [NUM_CORES*32-1:0] nonce_bases();
    logic [NUM_CORES*32-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_CORES; i++)
      b[i*32 +: 32] = 32'(64'(i) * (64'h1_0000_0000 / 64'(NUM_CORES)));
    return b;
  endfunction

  localparam logic [NUM_CORES*32-1:0] NONCE_BASES = nonce_bases();

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, REPORT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic [NUM_CORES-1:0] end_q, end_d;

  logic                 accept, cap_hit, cap_miss;
  logic [31:0]          hit_nonce;
  logic [255:0]         hit_hash;

  logic                     job_ready_q, res_valid_q, busy_q, res_found_q;
  logic [NUM_CORES-1:0]     core_en_q;
  logic [95:0]              data_q;
  logic [255:0]             midstate_q, target_q, res_hash_q;
  logic [NUM_CORES*32-1:0]  nonce_base_q;
  logic [31:0]              res_nonce_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    end_d     = end_q;
    accept    = 1'b0;
    cap_hit   = 1'b0;
    cap_miss  = 1'b0;
    hit_nonce = '0;
    hit_hash  = '0;
    // Descending scan so the lowest-index finder is the one left standing.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.core_found[i]) begin
        hit_nonce = bus.core_nonce[i*32 +: 32];
        hit_hash  = bus.core_hash[i*256 +: 256];
      end
    end
    case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          accept  = 1'b1;
          end_d   = '0;
          drop_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = bus.job_abort ? IDLE : RUN;
      end
      RUN: begin
        end_d = end_q | bus.core_end;
        if (bus.job_abort) begin
          drop_d  = 1'b1;
          cnt_d   = FLUSH_LOAD;
          state_d = FLUSH;
        end else if (|bus.core_found) begin
          cap_hit = 1'b1;
          cnt_d   = FLUSH_LOAD;
          state_d = FLUSH;
        end else if (&end_d) begin
          cap_miss = 1'b1;
          cnt_d    = FLUSH_LOAD;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.job_abort) drop_d = 1'b1;
        if (cnt_q == '0) state_d = (drop_q || bus.job_abort) ? IDLE : REPORT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      REPORT: begin
        if (bus.job_abort || bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_ready_q  <= 1'b1;
      core_en_q    <= '0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      data_q       <= '0;
      midstate_q   <= '0;
      target_q     <= '0;
      nonce_base_q <= '0;
      res_found_q  <= 1'b0;
      res_nonce_q  <= '0;
      res_hash_q   <= '0;
    end else begin
      job_ready_q <= (state_d == IDLE);
      core_en_q   <= {NUM_CORES{state_d == RUN}};
      res_valid_q <= (state_d == REPORT);
      busy_q      <= (state_d != IDLE);
      if (accept) begin
        data_q       <= bus.job_data;
        midstate_q   <= bus.job_midstate;
        target_q     <= bus.job_target;
        nonce_base_q <= NONCE_BASES;
      end
      if (cap_hit) begin
        res_found_q <= 1'b1;
        res_nonce_q <= hit_nonce;
        res_hash_q  <= hit_hash;
      end else if (cap_miss) begin
        res_found_q <= 1'b0;
        res_nonce_q <= '0;
        res_hash_q  <= '0;
      end
    end
  end

  assign bus.job_ready       = job_ready_q;
  assign bus.core_en         = core_en_q;
  assign bus.core_data       = data_q;
  assign bus.core_midstate   = midstate_q;
  assign bus.core_target     = target_q;
  assign bus.core_nonce_base = nonce_base_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_found       = res_found_q;
  assign bus.res_nonce       = res_nonce_q;
  assign bus.res_hash        = res_hash_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_mining_job_ctrl.sv
// Directed bench for mining_job_ctrl with a result scoreboard.
module tb_mining_job_ctrl;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  mining_job_if #(.NUM_CORES(NC)) bus();

  mining_job_ctrl #(.NUM_CORES(NC), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct packed {
    logic         found;
    logic [31:0]  nonce;
    logic [255:0] hash;
  } res_t;

  res_t sb[$];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nonce_of(input int i);
    return (32'(i) << 30) | 32'h0000_1234;
  endfunction

  function automatic logic [255:0] hash_of(input int i);
    return {8{32'(i + 1) * 32'h1111_1111}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [95:0] d);
    bus.job_data     = d;
    bus.job_midstate = {8{d[31:0]}};
    bus.job_target   = {4'h0, {252{1'b1}}};
    bus.job_valid    = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    check("load_ready", 256'(bus.job_ready), 256'(1'b0));
    check("load_en",    256'(bus.core_en),   256'(4'h0));
    check("load_busy",  256'(busy),          256'(1'b1));
    check("load_data",  256'(bus.core_data), 256'(d));
    check("load_base",  256'(bus.core_nonce_base),
          256'({32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}));
    tick();
    check("run_en", 256'(bus.core_en), 256'(4'hF));
  endtask

  task automatic wait_result(input int hold);
    res_t e;
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    check("res_timeout", 256'(bus.res_valid), 256'(1'b1));
    if (sb.size() == 0) begin
      check("sb_underflow", 256'(sb.size()), 256'(1));
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", 256'(bus.res_valid), 256'(1'b1));
      check("hold_nonce", 256'(bus.res_nonce), 256'(e.nonce));
      check("hold_hash",  bus.res_hash,        e.hash);
      tick();
    end
    check("res_found", 256'(bus.res_found), 256'(e.found));
    check("res_nonce", 256'(bus.res_nonce), 256'(e.nonce));
    check("res_hash",  bus.res_hash,        e.hash);
    check("res_en_off", 256'(bus.core_en),  256'(4'h0));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_dropped", 256'(bus.res_valid), 256'(1'b0));
    check("idle_ready",  256'(bus.job_ready), 256'(1'b1));
    check("idle_busy",   256'(busy),          256'(1'b0));
  endtask

  task automatic pulse_ends(input logic [NC-1:0] first_mask);
    for (int i = 0; i < NC; i++) begin
      if (first_mask[i]) begin
        bus.core_end = NC'(1 << i);
        tick();
        bus.core_end = '0;
        tick();
        check("end_still_run", 256'(bus.core_en), 256'(4'hF));
      end
    end
  endtask

  initial begin
    bus.job_valid    = 1'b0;
    bus.job_data     = '0;
    bus.job_midstate = '0;
    bus.job_target   = '0;
    bus.job_abort    = 1'b0;
    bus.core_found   = '0;
    bus.core_end     = '0;
    bus.res_ready    = 1'b0;
    for (int i = 0; i < NC; i++) begin
      bus.core_nonce[i*32 +: 32]  = nonce_of(i);
      bus.core_hash[i*256 +: 256] = hash_of(i);
    end

    // Reset state
    repeat (2) tick();
    check("rst_ready", 256'(bus.job_ready),       256'(1'b1));
    check("rst_en",    256'(bus.core_en),         256'(4'h0));
    check("rst_busy",  256'(busy),                256'(1'b0));
    check("rst_valid", 256'(bus.res_valid),       256'(1'b0));
    check("rst_base",  256'(bus.core_nonce_base), 256'(0));
    rst_n = 1'b1;
    tick();

    // Found on core 2, with flush timing and a 10-cycle result stall
    start_job(96'hA1A2_A3A4_A5A6_A7A8_A9AA_ABAC);
    bus.core_found = 4'b0100;
    sb.push_back('{1'b1, 32'h8000_1234, hash_of(2)});
    tick();
    bus.core_found = '0;
    check("flush1_en",    256'(bus.core_en),   256'(4'h0));
    check("flush1_valid", 256'(bus.res_valid), 256'(1'b0));
    tick();
    check("flush2_en",    256'(bus.core_en),   256'(4'h0));
    check("flush2_valid", 256'(bus.res_valid), 256'(1'b0));
    tick();
    check("report_valid", 256'(bus.res_valid), 256'(1'b1));
    wait_result(10);

    // Simultaneous finds on cores 1 and 3
    start_job(96'h1111_2222_3333_4444_5555_6666);
    tick();
    bus.core_found = 4'b1010;
    sb.push_back('{1'b1, nonce_of(1), hash_of(1)});
    tick();
    bus.core_found = '0;
    wait_result(0);

    // Exhaustion without a find
    start_job(96'h0BAD_F00D_0000_0000_0000_0001);
    pulse_ends(4'b1011);
    bus.core_end = 4'b0100;
    sb.push_back('{1'b0, 32'h0, 256'h0});
    tick();
    bus.core_end = '0;
    wait_result(0);

    // Final exhaustion coinciding with a find
    start_job(96'h0BAD_F00D_0000_0000_0000_0002);
    pulse_ends(4'b1011);
    bus.core_end   = 4'b0100;
    bus.core_found = 4'b0100;
    sb.push_back('{1'b1, nonce_of(2), hash_of(2)});
    tick();
    bus.core_end   = '0;
    bus.core_found = '0;
    wait_result(0);

    // Abort two cycles into RUN, then a normal job
    start_job(96'hDEAD_BEEF_0000_0000_0000_0003);
    tick();
    bus.job_abort = 1'b1;
    tick();
    bus.job_abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("abort_no_valid", 256'(bus.res_valid), 256'(1'b0));
      tick();
    end
    check("abort_idle_busy",  256'(busy),          256'(1'b0));
    check("abort_idle_ready", 256'(bus.job_ready), 256'(1'b1));
    start_job(96'hCAFE_0000_0000_0000_0000_0004);
    bus.core_found = 4'b0001;
    sb.push_back('{1'b1, nonce_of(0), hash_of(0)});
    tick();
    bus.core_found = '0;
    wait_result(0);

    // Asynchronous reset in the middle of RUN
    start_job(96'h5555_0000_0000_0000_0000_0005);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en",    256'(bus.core_en),   256'(4'h0));
    check("arst_busy",  256'(busy),          256'(1'b0));
    check("arst_ready", 256'(bus.job_ready), 256'(1'b1));
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 256'(busy), 256'(1'b0));
    check("sb_drained", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
